// File: rtl/lmul_arbiter.sv
// Round-robin front end sharing one BF16 multiplier among N_REQ lanes.
// An in-order tag FIFO steers each multiplier result back to its issuer.
module lmul_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BITW      = 16,
    parameter int TAG_DEPTH = 4,
    parameter int TAG_W     = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*BITW-1:0]     req_a,
    input  logic [N_REQ*BITW-1:0]     req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [BITW-1:0]           rsp_p,
    output logic                      m_i_valid,
    input  logic                      m_i_ready,
    output logic [BITW-1:0]           m_i_a,
    output logic [BITW-1:0]           m_i_b,
    input  logic                      m_o_valid,
    output logic                      m_o_ready,
    input  logic [BITW-1:0]           m_o_p,
    output logic [$clog2(TAG_DEPTH):0] inflight
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] tags [TAG_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [TAG_W-1:0] gnt;
    logic             gnt_any;
    logic [TAG_W:0]   idx;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] nxt_rr;
    logic             full;
    logic             empty;
    logic             issue;
    logic             push;
    logic             pop;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (idx >= (TAG_W+1)'(N_REQ))
                idx = idx - (TAG_W+1)'(N_REQ);
            if (req_valid[idx[TAG_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt     = idx[TAG_W-1:0];
            end
        end
    end

    assign full  = (count == CW'(TAG_DEPTH));
    assign empty = (count == '0);
    assign issue = rstn & gnt_any & ~full;
    assign head  = tags[rd_ptr];

    assign m_i_valid = issue;
    assign m_i_a     = req_a[gnt*BITW +: BITW];
    assign m_i_b     = req_b[gnt*BITW +: BITW];
    assign req_ready = (issue & m_i_ready) ? (N_REQ'(1) << gnt) : '0;

    assign rsp_valid = (~empty & m_o_valid) ? (N_REQ'(1) << head) : '0;
    assign rsp_p     = m_o_p;
    assign m_o_ready = ~empty & rsp_ready[head];
    assign inflight  = count;

    assign push   = m_i_valid & m_i_ready;
    assign pop    = m_o_valid & m_o_ready;
    assign nxt_rr = (gnt == TAG_W'(N_REQ - 1)) ? '0 : gnt + TAG_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tags   <= '{default: '0};
        end else begin
            if (push) begin
                tags[wr_ptr] <= gnt;
                wr_ptr       <= wr_ptr + PW'(1);
                rr_ptr       <= nxt_rr;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_lmul_arbiter.sv
// Random and directed stimulus for lmul_arbiter against a queue-based
// reference model, with a behavioural in-order multiplier as the far end.
module tb_lmul_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int MCAP = 6;

    typedef struct {
        int          tag;
        logic [15:0] p;
    } ent_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_p;
    logic           m_i_valid;
    logic           m_i_ready;
    logic [W-1:0]   m_i_a;
    logic [W-1:0]   m_i_b;
    logic           m_o_valid;
    logic           m_o_ready;
    logic [W-1:0]   m_o_p;
    logic [2:0]     inflight;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        q[$];
    logic [15:0] mq[$];
    int          rr;
    bit          e_push, e_pop, hs_i, hs_o;
    int          e_g;
    logic [15:0] e_p, hs_p;

    lmul_arbiter #(
        .N_REQ(N), .BITW(W), .TAG_DEPTH(D), .TAG_W(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .m_i_valid(m_i_valid), .m_i_ready(m_i_ready),
        .m_i_a(m_i_a), .m_i_b(m_i_b),
        .m_o_valid(m_o_valid), .m_o_ready(m_o_ready), .m_o_p(m_o_p),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truncating BF16 multiply for normal operands.
    function automatic logic [15:0] bf_mul(input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] pr;
        int          e;
        logic [6:0]  m;
        pr = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e  = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (pr[15]) begin
            m = pr[14:8];
            e = e + 1;
        end else begin
            m = pr[13:7];
        end
        return {a[15] ^ b[15], 8'(e), m};
    endfunction

    function automatic logic [15:0] rand_bf();
        return {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = rand_bf();
            req_b[i*W +: W] = rand_bf();
        end
    endtask

    task automatic settle();
        int  eg;
        bit  egv, eiss;
        m_o_valid = (mq.size() > 0);
        m_o_p     = m_o_valid ? mq[0] : 16'h0;
        #1;
        eg  = 0;
        egv = 0;
        for (int k = 0; k < N; k++)
            if (!egv && req_valid[(rr + k) % N]) begin
                egv = 1;
                eg  = (rr + k) % N;
            end
        eiss = rstn && egv && (q.size() < D);
        chk("m_i_valid", 32'(m_i_valid), 32'(eiss));
        chk("req_ready", 32'(req_ready),
            (eiss && m_i_ready) ? 32'(1) << eg : 32'(0));
        if (eiss) begin
            chk("m_i_a", 32'(m_i_a), 32'(req_a[eg*W +: W]));
            chk("m_i_b", 32'(m_i_b), 32'(req_b[eg*W +: W]));
        end
        chk("rsp_valid", 32'(rsp_valid),
            (q.size() > 0 && m_o_valid) ? 32'(1) << q[0].tag : 32'(0));
        chk("m_o_ready", 32'(m_o_ready),
            (q.size() > 0) ? 32'(rsp_ready[q[0].tag]) : 32'(0));
        if (q.size() > 0 && m_o_valid)
            chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
        chk("inflight", 32'(inflight), 32'(q.size()));
        e_push = eiss && m_i_ready;
        e_pop  = (q.size() > 0) && m_o_valid && rsp_ready[q[0].tag];
        e_g    = eg;
        e_p    = bf_mul(req_a[eg*W +: W], req_b[eg*W +: W]);
        hs_i   = m_i_valid && m_i_ready;
        hs_p   = bf_mul(m_i_a, m_i_b);
        hs_o   = m_o_valid && m_o_ready;
    endtask

    task automatic advance();
        ent_t ent;
        @(posedge clk);
        #1;
        if (hs_o) void'(mq.pop_front());
        if (hs_i) mq.push_back(hs_p);
        if (e_pop) void'(q.pop_front());
        if (e_push) begin
            ent.tag = e_g;
            ent.p   = e_p;
            q.push_back(ent);
            rr = (e_g + 1) % N;
        end
        m_i_ready = (mq.size() < MCAP);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        rstn      = 1'b0;
        rr        = 0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        m_i_ready = 1'b1;
        rand_ops();
        #3;
        settle();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_inflight", 32'(inflight), 32'(0));
        advance();
        advance();
        rstn      = 1'b1;
        req_valid = '0;
        cyc(2);

        // Single request from lane 0
        req_valid = 4'b0001;
        req_a[0 +: W] = 16'h3F80;
        req_b[0 +: W] = 16'h4000;
        settle();
        chk("single_issue", 32'(req_ready), 32'(1));
        advance();
        req_valid = '0;
        settle();
        chk("single_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("single_rsp_p", 32'(rsp_p), 32'h4000);
        chk("single_inflight", 32'(inflight), 32'(1));
        advance();
        settle();
        chk("single_done", 32'(inflight), 32'(0));
        advance();

        // All lanes streaming, responders ready
        req_valid = 4'hF;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            cyc(1);
        end
        req_valid = '0;
        cyc(6);

        // Lane 0 responder stalled: FIFO fills
        req_valid = 4'b0011;
        rsp_ready = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            cyc(1);
        end
        settle();
        chk("fill_inflight", 32'(inflight), 32'(D));
        chk("fill_no_ready", 32'(req_ready), 32'(0));
        advance();
        req_valid = '0;
        rsp_ready = 4'hF;
        cyc(8);
        settle();
        chk("drain_inflight", 32'(inflight), 32'(0));
        advance();

        // Reset with three operations outstanding
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        cyc(3);
        settle();
        chk("pre_rst_inflight", 32'(inflight), 32'(3));
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_inflight", 32'(inflight), 32'(0));
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_m_i_valid", 32'(m_i_valid), 32'(0));
        q.delete();
        mq.delete();
        rr = 0;
        hs_i = 0; hs_o = 0; e_push = 0; e_pop = 0;
        advance();
        cyc(1);
        rstn = 1'b1;
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        rand_ops();
        settle();
        chk("post_rst_issue", 32'(req_ready), 32'(2));
        advance();
        req_valid = '0;
        settle();
        chk("post_rst_rsp", 32'(rsp_valid), 32'(2));
        advance();
        settle();
        chk("post_rst_done", 32'(inflight), 32'(0));
        advance();

        // rr_ptr is now 2; lane 2 idle
        req_valid = 4'b1011;
        settle();
        chk("rr_first_grant", 32'(req_ready), 32'(8));
        advance();
        for (int i = 0; i < 9; i++) begin
            rand_ops();
            cyc(1);
        end
        req_valid = '0;
        cyc(6);

        // Random traffic with multiplier and responder backpressure
        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom);
            for (int j = 0; j < N; j++)
                rsp_ready[j] = ($urandom_range(0, 3) != 0);
            m_i_ready = (mq.size() < MCAP) && ($urandom_range(0, 3) != 0);
            rand_ops();
            cyc(1);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        cyc(12);
        settle();
        chk("final_inflight", 32'(inflight), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
